// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the line/frame buffer RAM and its stream reader.
package etrange_ram_pkg;
   localparam int unsigned RAM_ADDR_SIZE = 6;
   localparam int unsigned RAM_DATA_SIZE = 32;

   typedef enum logic [1:0] {IDLE, RUN, DONE} rd_state_t;
endpackage

// File: rtl/ram_stream_reader_if.sv
// Stream output and RAM read port of the stream reader.
interface ram_stream_reader_if import etrange_ram_pkg::*; #(
   parameter int unsigned ADDR_SIZE = RAM_ADDR_SIZE,
   parameter int unsigned DATA_SIZE = RAM_DATA_SIZE
);
   logic [DATA_SIZE-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [ADDR_SIZE-1:0] ram_addr;
   logic [DATA_SIZE-1:0] ram_data;

   modport master (output out_data, out_valid, ram_addr, input out_ready, ram_data);
   modport slave  (input out_data, out_valid, ram_addr, output out_ready, ram_data);
endinterface

// File: rtl/ram_stream_reader_fifo2.sv
// Two-entry synchronous FIFO; flush empties it and takes priority over push/pop.
module fifo2 #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [1:0]       count
);
   logic [WIDTH-1:0] mem [2];
   logic             wr_idx;
   logic             rd_idx;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (count != 2'd0);
   assign do_push = push && ((count != 2'd2) || do_pop);
   assign dout    = mem[rd_idx];

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
         wr_idx <= 1'b0;
         rd_idx <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         wr_idx <= 1'b0;
         rd_idx <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_idx] <= din;
            wr_idx      <= ~wr_idx;
         end
         if (do_pop) rd_idx <= ~rd_idx;
         count <= count + 2'(do_push) - 2'(do_pop);
      end
   end
endmodule

// File: rtl/ram_stream_reader.sv
// Burst reader: turns (base_addr, length) into a valid/ready stream from RAM port B,
// hiding the 1-cycle read latency with a 2-entry FIFO and credit-based issue.
module ram_stream_reader import etrange_ram_pkg::*; #(
   parameter int unsigned ADDR_SIZE = RAM_ADDR_SIZE,
   parameter int unsigned DATA_SIZE = RAM_DATA_SIZE,
   parameter int unsigned LEN_SIZE  = ADDR_SIZE + 1
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [ADDR_SIZE-1:0] base_addr,
   input  logic [LEN_SIZE-1:0]  length,
   output logic                 busy,
   output logic                 done,
   ram_stream_reader_if.master  bus
);
   rd_state_t            state;
   logic [ADDR_SIZE-1:0] rd_ptr;
   logic [LEN_SIZE-1:0]  issue_cnt;
   logic [LEN_SIZE-1:0]  rem_cnt;
   logic                 inflight;
   logic [1:0]           fifo_cnt;
   logic [DATA_SIZE-1:0] fifo_dout;
   logic                 pop;
   logic                 issue;
   logic                 flush;
   logic [2:0]           occ;

   assign pop   = bus.out_valid && bus.out_ready;
   assign flush = abort && (state != IDLE);
   // Credit: words held plus the read in flight, minus this cycle's pop, must stay below 2.
   assign occ   = 3'(fifo_cnt) + 3'(inflight);
   assign issue = (state == RUN) && !abort && (issue_cnt != '0) && (occ < (3'd2 + 3'(pop)));

   assign busy          = (state != IDLE);
   assign bus.ram_addr  = rd_ptr;
   assign bus.out_data  = fifo_dout;
   assign bus.out_valid = (fifo_cnt != 2'd0);

   fifo2 #(.WIDTH(DATA_SIZE)) u_fifo (
      .clk   (clk),
      .nrst  (nrst),
      .push  (inflight),
      .pop   (pop),
      .flush (flush),
      .din   (bus.ram_data),
      .dout  (fifo_dout),
      .count (fifo_cnt)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state     <= IDLE;
         rd_ptr    <= '0;
         issue_cnt <= '0;
         rem_cnt   <= '0;
         inflight  <= 1'b0;
         done      <= 1'b0;
      end else begin
         done     <= 1'b0;
         inflight <= issue;
         if (issue) begin
            rd_ptr    <= rd_ptr + ADDR_SIZE'(1);
            issue_cnt <= issue_cnt - LEN_SIZE'(1);
         end
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (length != '0) begin
                     state     <= RUN;
                     rd_ptr    <= base_addr;
                     issue_cnt <= length;
                     rem_cnt   <= length;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (abort) begin
                  state <= IDLE;
               end else if (pop) begin
                  rem_cnt <= rem_cnt - LEN_SIZE'(1);
                  if (rem_cnt == LEN_SIZE'(1)) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader with a registered-read RAM model.
module tb_ram_stream_reader;
   localparam int unsigned AW = 6;
   localparam int unsigned DW = 32;
   localparam int unsigned LW = 7;

   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [LW-1:0] length = '0;
   logic          busy;
   logic          done;
   logic          rnd_ready = 1'b0;
   logic          rnd_bit = 1'b1;

   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] exp_q [$];
   int            n_cmp = 0;
   int            n_err = 0;
   int            xfer_cnt = 0;
   int            done_cnt = 0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;

   ram_stream_reader_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();

   ram_stream_reader #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .LEN_SIZE(LW)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .start     (start),
      .abort     (abort),
      .base_addr (base_addr),
      .length    (length),
      .busy      (busy),
      .done      (done),
      .bus       (bus.master)
   );

   always #5 clk = ~clk;

   initial for (int i = 0; i < 2**AW; i++) mem[i] = 32'hA000 + 32'(i);

   always @(posedge clk) bus.ram_data <= mem[bus.ram_addr];
   always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));
   assign bus.out_ready = rnd_ready ? rnd_bit : 1'b1;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference stream: every accepted word must be the next expected address-ordered word.
   always @(negedge clk) begin
      if (nrst) begin
         if (prev_stall) begin
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_data", bus.out_data, prev_data);
         end
         if (bus.out_valid && bus.out_ready && !abort) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL extra_word: got %h, expected no word", bus.out_data);
            end else begin
               check("stream_word", bus.out_data, exp_q.pop_front());
            end
         end
         if (done) begin
            done_cnt++;
            check("done_drained", 32'(exp_q.size()), 32'd0);
         end
         prev_stall = bus.out_valid && !bus.out_ready && !abort;
         prev_data  = bus.out_data;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_burst(input int b, input int l);
      base_addr = AW'(b);
      length    = LW'(l);
      start     = 1'b1;
      for (int i = 0; i < l; i++) exp_q.push_back(32'hA000 + 32'((b + i) % (2**AW)));
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int max_cycles, input string name);
      int k = 0;
      while (!done && k < max_cycles) begin
         tick();
         k++;
      end
      n_cmp++;
      if (!done) begin
         n_err++;
         $display("FAIL %s: done not seen within %0d cycles", name, max_cycles);
      end
      tick();
      check({name, "_busy_low"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int x0;
      int d0;
      int k;
      logic [DW-1:0] wrap_exp [8];
      wrap_exp = '{32'hA03C, 32'hA03D, 32'hA03E, 32'hA03F, 32'hA000, 32'hA001, 32'hA002, 32'hA003};

      #3;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_data", bus.out_data, 32'd0);
      check("rst_addr", 32'(bus.ram_addr), 32'd0);
      tick();
      nrst = 1'b1;
      tick();

      // 1: basic burst, latency and full throughput
      d0 = done_cnt;
      start_burst(4, 8);
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_lat0", 32'(bus.out_valid), 32'd0);
      tick();
      check("t1_lat1", 32'(bus.out_valid), 32'd0);
      tick();
      for (int i = 0; i < 8; i++) begin
         check("t1_valid", 32'(bus.out_valid), 32'd1);
         check("t1_data", bus.out_data, 32'hA004 + 32'(i));
         tick();
      end
      check("t1_done", 32'(done), 32'd1);
      tick();
      check("t1_done_end", 32'(done), 32'd0);
      check("t1_busy_end", 32'(busy), 32'd0);
      check("t1_done_once", 32'(done_cnt - d0), 32'd1);

      // 2: address wrap
      start_burst(60, 8);
      tick();
      tick();
      for (int i = 0; i < 8; i++) begin
         check("t2_data", bus.out_data, wrap_exp[i]);
         tick();
      end
      check("t2_done", 32'(done), 32'd1);
      tick();

      // 3: full-depth burst and random bursts under random back-pressure
      rnd_ready = 1'b1;
      x0 = xfer_cnt;
      start_burst(int'($urandom_range(0, 63)), 64);
      wait_done(400, "t3_full");
      check("t3_count", 32'(xfer_cnt - x0), 32'd64);
      for (int r = 0; r < 4; r++) begin
         int l;
         l  = int'($urandom_range(1, 64));
         x0 = xfer_cnt;
         start_burst(int'($urandom_range(0, 63)), l);
         wait_done(400, "t3_rand");
         check("t3_rand_count", 32'(xfer_cnt - x0), 32'(l));
      end
      rnd_ready = 1'b0;
      tick();

      // 4: zero-length burst
      x0 = xfer_cnt;
      d0 = done_cnt;
      start_burst(9, 0);
      check("t4_busy", 32'(busy), 32'd1);
      check("t4_done", 32'(done), 32'd1);
      check("t4_valid", 32'(bus.out_valid), 32'd0);
      tick();
      check("t4_busy_end", 32'(busy), 32'd0);
      check("t4_done_end", 32'(done), 32'd0);
      tick();
      check("t4_no_words", 32'(xfer_cnt - x0), 32'd0);
      check("t4_done_once", 32'(done_cnt - d0), 32'd1);

      // 5: abort after three transfers, then a fresh burst
      x0 = xfer_cnt;
      start_burst(20, 10);
      k = 0;
      while ((xfer_cnt - x0) < 3 && k < 20) begin
         tick();
         k++;
      end
      check("t5_three", 32'(xfer_cnt - x0), 32'd3);
      abort = 1'b1;
      d0 = done_cnt;
      tick();
      abort = 1'b0;
      exp_q.delete();
      check("t5_valid_low", 32'(bus.out_valid), 32'd0);
      check("t5_busy_low", 32'(busy), 32'd0);
      repeat (3) tick();
      check("t5_no_done", 32'(done_cnt - d0), 32'd0);
      check("t5_no_more", 32'(xfer_cnt - x0), 32'd3);
      start_burst(0, 2);
      tick();
      tick();
      check("t5_w0", bus.out_data, 32'hA000);
      tick();
      check("t5_w1", bus.out_data, 32'hA001);
      wait_done(10, "t5_done");

      // 6: asynchronous reset mid-burst
      start_burst(30, 20);
      repeat (3) tick();
      check("t6_valid_pre", 32'(bus.out_valid), 32'd1);
      #1 nrst = 1'b0;
      #1;
      check("t6_valid", 32'(bus.out_valid), 32'd0);
      check("t6_data", bus.out_data, 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_addr", 32'(bus.ram_addr), 32'd0);
      exp_q.delete();
      tick();
      nrst = 1'b1;
      tick();
      x0 = xfer_cnt;
      start_burst(7, 3);
      wait_done(20, "t6_done");
      check("t6_count", 32'(xfer_cnt - x0), 32'd3);
      check("end_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
